// File: rtl/iic_dac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iic_dac_ctrl
// Brief    : Multi-channel I2C DAC write/readback sequencer with round-robin
//            arbitration, per-transfer timeout and optional write verify
//            (enable with `define DAC_READBACK_VERIFY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module iic_dac_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0001100,
    parameter int         NUM_CH      = 2,
    parameter int         DATA_W      = 12,
    parameter int         TIMEOUT_CYC = 4096,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_CH-1:0]        wr_start_i,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
    input  logic                     rd_start_i,
    input  logic [CH_W-1:0]          rd_ch_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    input  logic                     err_clr_i,
    output logic [6:0]               device_addr_o,
    output logic                     iic_wr_req_o,
    output logic [7:0]               iic_wr_addr_o,
    output logic [15:0]              iic_wr_data_o,
    input  logic                     iic_wr_ack_i,
    input  logic                     iic_wr_done_i,
    output logic                     iic_rd_req_o,
    output logic [7:0]               iic_rd_addr_o,
    input  logic                     iic_rd_ack_i,
    input  logic                     iic_rd_done_i,
    input  logic [15:0]              iic_rd_data_i
);

    localparam int         TMO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] c_ERR_TMO    = 2'b01;
`ifdef DAC_READBACK_VERIFY_EN
    localparam logic [1:0] c_ERR_VERIFY = 2'b10;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_REQ   = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_WAIT  = 3'd4
`ifdef DAC_READBACK_VERIFY_EN
        ,
        S_VRD_REQ  = 3'd5,
        S_VRD_WAIT = 3'd6
`endif
    } state_t;

    state_t                         r_state;
    logic [NUM_CH-1:0]              r_pend;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_data;
    logic                           r_rd_pend;
    logic [CH_W-1:0]                r_rd_ch;
    logic [CH_W-1:0]                r_rr_next;
    logic [TMO_W-1:0]               r_tmo_cnt;
    logic [DATA_W-1:0]              r_rd_data;
    logic                           r_rd_valid;
    logic                           r_err;
    logic [1:0]                     r_err_code;
    logic                           r_wr_req;
    logic [7:0]                     r_wr_addr;
    logic [15:0]                    r_wr_data;
    logic                           r_rd_req;
    logic [7:0]                     r_rd_addr;
`ifdef DAC_READBACK_VERIFY_EN
    logic [DATA_W-1:0]              r_snap;
`endif

    logic                           w_found;
    logic [CH_W-1:0]                w_sel;
    logic                           w_tmo;
    logic                           w_unused;

    // Wraps base+offs into 0..NUM_CH-1 without a modulo operator.
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && r_pend[rr_idx(r_rr_next, i)]) begin
                w_found = 1'b1;
                w_sel   = rr_idx(r_rr_next, i);
            end
        end
    end

    assign w_tmo    = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign w_unused = ^iic_rd_data_i[15:DATA_W];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_data     <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_ch    <= '0;
            r_rr_next  <= '0;
            r_tmo_cnt  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
`ifdef DAC_READBACK_VERIFY_EN
            r_snap     <= '0;
`endif
        end else begin
            r_rd_valid <= 1'b0;
            // Clear first so a same-cycle error assignment below takes priority.
            if (err_clr_i) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end

            case (r_state)
                S_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (r_rd_pend) begin
                        r_state   <= S_RD_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= 8'd1 << r_rd_ch;
                    end else if (w_found) begin
                        r_state       <= S_WR_REQ;
                        r_wr_req      <= 1'b1;
                        r_wr_addr     <= 8'd1 << w_sel;
                        r_wr_data     <= {2'b00, {(14-DATA_W){1'b0}}, r_data[w_sel]};
                        r_pend[w_sel] <= 1'b0;
                        r_rr_next     <= rr_idx(w_sel, 1);
`ifdef DAC_READBACK_VERIFY_EN
                        r_snap        <= r_data[w_sel];
`endif
                    end
                end
                S_WR_REQ: begin
                    if (iic_wr_ack_i) begin
                        r_state   <= S_WR_WAIT;
                        r_wr_req  <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_wr_req   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (iic_wr_done_i) begin
`ifdef DAC_READBACK_VERIFY_EN
                        r_state   <= S_VRD_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= r_wr_addr;
                        r_tmo_cnt <= '0;
`else
                        r_state   <= S_IDLE;
`endif
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_RD_REQ: begin
                    if (iic_rd_ack_i) begin
                        r_state   <= S_RD_WAIT;
                        r_rd_req  <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_rd_req   <= 1'b0;
                        r_rd_pend  <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (iic_rd_done_i) begin
                        r_state    <= S_IDLE;
                        r_rd_data  <= iic_rd_data_i[DATA_W-1:0];
                        r_rd_valid <= 1'b1;
                        r_rd_pend  <= 1'b0;
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_rd_pend  <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
`ifdef DAC_READBACK_VERIFY_EN
                S_VRD_REQ: begin
                    if (iic_rd_ack_i) begin
                        r_state   <= S_VRD_WAIT;
                        r_rd_req  <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_rd_req   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_VRD_WAIT: begin
                    if (iic_rd_done_i) begin
                        r_state <= S_IDLE;
                        if (iic_rd_data_i[DATA_W-1:0] != r_snap) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_VERIFY;
                        end
                    end else if (w_tmo) begin
                        r_state    <= S_IDLE;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                end
            endcase

            // New strobes win over the FSM clearing the same channel's pend bit.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_start_i[ch]) begin
                    r_pend[ch] <= 1'b1;
                    r_data[ch] <= wr_data_i[ch*DATA_W +: DATA_W];
                end
            end
            if (rd_start_i && !r_rd_pend) begin
                r_rd_pend <= 1'b1;
                r_rd_ch   <= rd_ch_i;
            end
        end
    end

    assign busy_o        = (r_state != S_IDLE) || (|r_pend) || r_rd_pend;
    assign rd_data_o     = r_rd_data;
    assign rd_valid_o    = r_rd_valid;
    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign device_addr_o = SLAVE_ADDR;
    assign iic_wr_req_o  = r_wr_req;
    assign iic_wr_addr_o = r_wr_addr;
    assign iic_wr_data_o = r_wr_data;
    assign iic_rd_req_o  = r_rd_req;
    assign iic_rd_addr_o = r_rd_addr;

endmodule
`default_nettype wire
